diff_monitor: RTL
=================

// Module: diff_monitor
//
// PURPOSE
//   Downstream consumer of the dual-counter compare stage. Takes both 32-bit
//   counter values and the diff flag every clock. Tracks how long the
//   counters stay diverged, and captures the counter values at the first
//   divergence. Raises a sticky alarm once a run of consecutive mismatches
//   reaches THRESH. Also flags a sticky error when diff disagrees with its
//   own compare of cnt1 and cnt2.
//
// PARAMETERS
//   WIDTH     32   width of cnt1/cnt2 and of the snapshot outputs
//   THRESH    4    consecutive diff cycles that raise alarm; legal 1..2^RUN_W-1
//   RUN_W     8    width of run_len; saturates at all-ones
//   TOT_W     16   width of mismatch_cycles; saturates at all-ones
//
// PORTS
//   clk              in   1       clock, rising edge
//   rstn             in   1       asynchronous active-low reset
//   cnt1             in   WIDTH   counter 1 value
//   cnt2             in   WIDTH   counter 2 value
//   diff             in   1       high when cnt1 != cnt2
//   clr              in   1       synchronous clear, one-cycle pulse
//   state            out  2       0=MATCH 1=DIVERGE 2=ALARM (3 unused)
//   alarm            out  1       sticky; high while state==ALARM
//   run_len          out  RUN_W   length of current consecutive-diff run
//   mismatch_cycles  out  TOT_W   total diff cycles since reset/clr
//   snap_valid       out  1       first_cnt1/first_cnt2 hold a capture
//   first_cnt1       out  WIDTH   cnt1 at first diff since reset/clr
//   first_cnt2       out  WIDTH   cnt2 at first diff since reset/clr
//   chk_err          out  1       sticky; diff != (cnt1 != cnt2) seen
//
// BEHAVIOUR
//   - All outputs are registered. rstn low forces state=MATCH and sets every
//     output to 0, asynchronously.
//   - Inputs are sampled on each rising edge. Results appear on the outputs
//     after that edge (latency 1).
//   - clr has priority over everything else. On an edge with clr=1:
//     state=MATCH, and alarm, run_len, mismatch_cycles, snap_valid,
//     first_cnt1, first_cnt2 and chk_err all go to 0. That cycle's diff is
//     not counted and not captured.
//   - mismatch_cycles: +1 on every edge with diff=1 (no clr). Holds at
//     all-ones.
//   - Snapshot: on an edge with diff=1 and snap_valid=0, first_cnt1<=cnt1,
//     first_cnt2<=cnt2 and snap_valid<=1. After that the snapshot is frozen
//     until clr.
//   - chk_err: set on any edge where diff != (cnt1 != cnt2). Stays set until
//     clr or reset. It does not affect the FSM, which uses diff only.
//   - FSM states:
//     - MATCH:
//       - diff=0: stay; run_len=0.
//       - diff=1: run_len=1; go to ALARM if THRESH==1, else DIVERGE.
//     - DIVERGE:
//       - diff=1: run_len+1; go to ALARM when the new run_len == THRESH.
//       - diff=0: go to MATCH; run_len=0.
//     - ALARM:
//       - alarm=1. The state holds regardless of diff until clr.
//       - diff=1: run_len increments, saturating.
//       - diff=0: run_len=0, but the state stays ALARM.
//   - alarm is high exactly when state==ALARM. It rises on the edge that
//     samples the THRESH-th consecutive diff.
//   - Wrap-around: a counter wrapping 0xFFFFFFFF->0 is a normal value; the
//     block does no special handling.
//   - Simultaneous events:
//     - clr with diff=1: clr wins.
//     - First diff that also reaches THRESH (THRESH==1): the snapshot and
//       alarm set on the same edge.
//   - Reset mid-run: every output returns to 0 at once. The next diff
//     starts a fresh run and takes a fresh snapshot.
//
// TESTING
//   1. Reset, then 10 cycles cnt1=cnt2=5..14, diff=0 -> state=0, all
//      outputs 0, chk_err=0.
//   2. Diverge for 3 cycles (cnt1=20, cnt2=7 first), THRESH=4, then match ->
//      run_len goes 1,2,3,0; alarm stays 0; snapshot=20/7;
//      mismatch_cycles=3.
//   3. 4 consecutive diffs starting cnt1=0x10, cnt2=0x0 -> alarm rises on
//      the 4th edge; state=2; alarm holds after diff returns to 0; clr ->
//      all outputs 0.
//   4. cnt1=cnt2=9 with diff=1 forced -> chk_err=1 next cycle and stays 1
//      after diff=0; clr clears it.
//   5. 300 diff cycles with RUN_W=8 -> run_len saturates at 255;
//      mismatch_cycles=300.
//   6. rstn low while state=DIVERGE with run_len=2 -> all outputs 0 at
//      once; after release, one diff gives run_len=1 and a new snapshot.

Source files
------------

// File: rtl/diff_monitor.sv
// Watches the dual-counter compare stage: tracks divergence runs, snapshots the
// first diverged pair, raises a sticky alarm and cross-checks the diff flag.
module diff_monitor #(
    parameter int WIDTH  = 32,
    parameter int THRESH = 4,
    parameter int RUN_W  = 8,
    parameter int TOT_W  = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] cnt1,
    input  logic [WIDTH-1:0] cnt2,
    input  logic             diff,
    input  logic             clr,
    output logic [1:0]       state,
    output logic             alarm,
    output logic [RUN_W-1:0] run_len,
    output logic [TOT_W-1:0] mismatch_cycles,
    output logic             snap_valid,
    output logic [WIDTH-1:0] first_cnt1,
    output logic [WIDTH-1:0] first_cnt2,
    output logic             chk_err
);

    typedef enum logic [1:0] {
        MATCH   = 2'd0,
        DIVERGE = 2'd1,
        ALARM   = 2'd2
    } state_e;

    localparam logic [RUN_W-1:0] THRESH_L = RUN_W'(THRESH);

    state_e             state_q;
    logic               alarm_q;
    logic [RUN_W-1:0]   runLen_q;
    logic [TOT_W-1:0]   totCycles_q;
    logic               snapValid_q;
    logic [WIDTH-1:0]   firstCnt1_q;
    logic [WIDTH-1:0]   firstCnt2_q;
    logic               chkErr_q;

    logic [RUN_W-1:0]   runLen_d;
    logic               selfDiff;

    // Saturating increment of the run length, shared by DIVERGE and ALARM.
    assign runLen_d = (runLen_q == '1) ? runLen_q : runLen_q + RUN_W'(1);
    assign selfDiff = (cnt1 != cnt2);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= MATCH;
            alarm_q     <= 1'b0;
            runLen_q    <= '0;
            totCycles_q <= '0;
            snapValid_q <= 1'b0;
            firstCnt1_q <= '0;
            firstCnt2_q <= '0;
            chkErr_q    <= 1'b0;
        end else if (clr) begin
            state_q     <= MATCH;
            alarm_q     <= 1'b0;
            runLen_q    <= '0;
            totCycles_q <= '0;
            snapValid_q <= 1'b0;
            firstCnt1_q <= '0;
            firstCnt2_q <= '0;
            chkErr_q    <= 1'b0;
        end else begin
            if (diff && (totCycles_q != '1)) begin
                totCycles_q <= totCycles_q + TOT_W'(1);
            end
            if (diff && !snapValid_q) begin
                firstCnt1_q <= cnt1;
                firstCnt2_q <= cnt2;
                snapValid_q <= 1'b1;
            end
            if (diff != selfDiff) begin
                chkErr_q <= 1'b1;
            end

            // The FSM follows the diff flag only; chk_err never steers it.
            case (state_q)
                MATCH: begin
                    if (diff) begin
                        runLen_q <= RUN_W'(1);
                        if (THRESH == 1) begin
                            state_q <= ALARM;
                            alarm_q <= 1'b1;
                        end else begin
                            state_q <= DIVERGE;
                        end
                    end else begin
                        runLen_q <= '0;
                    end
                end
                DIVERGE: begin
                    if (diff) begin
                        runLen_q <= runLen_d;
                        if (runLen_d == THRESH_L) begin
                            state_q <= ALARM;
                            alarm_q <= 1'b1;
                        end
                    end else begin
                        state_q  <= MATCH;
                        runLen_q <= '0;
                    end
                end
                ALARM: begin
                    alarm_q  <= 1'b1;
                    runLen_q <= diff ? runLen_d : '0;
                end
                default: begin
                    state_q  <= MATCH;
                    alarm_q  <= 1'b0;
                    runLen_q <= '0;
                end
            endcase
        end
    end

    assign state           = state_q;
    assign alarm           = alarm_q;
    assign run_len         = runLen_q;
    assign mismatch_cycles = totCycles_q;
    assign snap_valid      = snapValid_q;
    assign first_cnt1      = firstCnt1_q;
    assign first_cnt2      = firstCnt2_q;
    assign chk_err         = chkErr_q;

endmodule
